// File: rtl/ahb_tl_downsize_bridge_pkg.sv
// Shared AHB and TL-UL encodings used by the downsize bridge and its lane helper.
package ahb_tl_downsize_bridge_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int TL_SRCW = 8;

  typedef enum logic [2:0] {
    TL_PUT_FULL_DATA    = 3'd0,
    TL_PUT_PARTIAL_DATA = 3'd1,
    TL_GET              = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  // A transfer wider than one TL word is split, so each beat is at most one TL word.
  function automatic logic [1:0] tl_size_clamp(input logic [2:0] hsize, input int tl_off_w);
    return (int'(hsize) > tl_off_w) ? 2'(tl_off_w) : hsize[1:0];
  endfunction

endpackage

// File: rtl/tl_lane_mask.sv
// Byte-lane helper: turns a beat offset within the AHB word and a TL size into
// the TL byte mask and the index of the TL-wide slice of the AHB data bus.
module tl_lane_mask #(
  parameter int AhbDw = 64,
  parameter int TlDw  = 32
) (
  input  logic [$clog2(AhbDw/8)-1:0]                             offset,
  input  logic [1:0]                                             size,
  output logic [TlDw/8-1:0]                                      mask,
  output logic [((AhbDw > TlDw) ? $clog2(AhbDw/TlDw) : 1)-1:0]   lane
);

  localparam int TlBytes = TlDw / 8;
  localparam int TlOffW  = $clog2(TlBytes);
  localparam int LaneW   = (AhbDw > TlDw) ? $clog2(AhbDw / TlDw) : 1;

  logic [TlOffW-1:0] byte_off;

  always_comb begin
    byte_off = offset[TlOffW-1:0];
    mask     = '0;
    for (int b = 0; b < TlBytes; b++) begin
      if ((b >= int'(byte_off)) && (b < int'(byte_off) + (1 << size))) begin
        mask[b] = 1'b1;
      end
    end
    lane = LaneW'(offset >> TlOffW);
  end

endmodule

// File: rtl/ahb_tl_downsize_bridge.sv
// AHB slave to TL-UL host bridge that splits wide AHB transfers into a sequence
// of single-outstanding TL-UL beats, with a two-cycle AHB error on failure.
module ahb_tl_downsize_bridge
  import ahb_tl_downsize_bridge_pkg::*;
#(
  parameter int                 AhbDw    = 64,
  parameter int                 TlDw     = 32,
  parameter int                 AddrW    = 32,
  parameter logic [TL_SRCW-1:0] SourceId = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hsel_i,
  input  logic [AddrW-1:0]   haddr_i,
  input  logic [1:0]         htrans_i,
  input  logic               hwrite_i,
  input  logic [2:0]         hsize_i,
  input  logic [AhbDw-1:0]   hwdata_i,
  input  logic               hready_i,
  output logic               hreadyout_o,
  output logic               hresp_o,
  output logic [AhbDw-1:0]   hrdata_o,
  output logic               a_valid_o,
  input  logic               a_ready_i,
  output logic [2:0]         a_opcode_o,
  output logic [1:0]         a_size_o,
  output logic [AddrW-1:0]   a_address_o,
  output logic [TlDw/8-1:0]  a_mask_o,
  output logic [TlDw-1:0]    a_data_o,
  output logic [TL_SRCW-1:0] a_source_o,
  input  logic               d_valid_i,
  output logic               d_ready_o,
  input  logic [2:0]         d_opcode_i,
  input  logic               d_error_i,
  input  logic [TlDw-1:0]    d_data_i
);

  localparam int AhbBytes = AhbDw / 8;
  localparam int TlBytes  = TlDw / 8;
  localparam int AhbOffW  = $clog2(AhbBytes);
  localparam int TlOffW   = $clog2(TlBytes);
  localparam int NumLanes = AhbDw / TlDw;
  localparam int LaneW    = (NumLanes > 1) ? $clog2(NumLanes) : 1;
  localparam int BeatW    = $clog2(NumLanes) + 1;

  if ((AhbDw % TlDw != 0) || (AhbDw < TlDw)) begin : g_param_check
    $fatal(1, "ahb_tl_downsize_bridge: AhbDw must be a whole multiple of TlDw");
  end

  typedef enum logic [2:0] {IDLE, WDATA, REQ, RSP, ERR1, ERR2} state_e;

  state_e             state_q, state_d;
  logic [AddrW-1:0]   addr_q;
  logic               write_q;
  logic [2:0]         size_q;
  logic [AhbDw-1:0]   wdata_q;
  logic [AhbDw-1:0]   hrdata_q;
  logic [BeatW-1:0]   beat_q;
  logic [BeatW-1:0]   last_beat_q;

  logic               accept;
  logic               bad_xfer;
  logic [AhbOffW-1:0] align_mask;
  logic [BeatW-1:0]   last_beat_d;
  logic [AddrW-1:0]   beat_addr;
  logic [1:0]         tl_size;
  logic [LaneW-1:0]   lane;
  logic               unused_d_opcode;

  assign unused_d_opcode = ^d_opcode_i;

  // Decode of the AHB address phase: acceptance, legality and how many TL beats it needs.
  always_comb begin
    accept      = hsel_i && hready_i && ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ));
    align_mask  = AhbOffW'((1 << hsize_i) - 1);
    bad_xfer    = (int'(hsize_i) > AhbOffW) || ((haddr_i[AhbOffW-1:0] & align_mask) != '0);
    last_beat_d = '0;
    if (int'(hsize_i) > TlOffW) begin
      last_beat_d = BeatW'((1 << (int'(hsize_i) - TlOffW)) - 1);
    end
  end

  assign beat_addr = addr_q + (AddrW'(beat_q) << TlOffW);
  assign tl_size   = tl_size_clamp(size_q, TlOffW);

  tl_lane_mask #(
    .AhbDw (AhbDw),
    .TlDw  (TlDw)
  ) u_lane_mask (
    .offset (beat_addr[AhbOffW-1:0]),
    .size   (tl_size),
    .mask   (a_mask_o),
    .lane   (lane)
  );

  // A-channel fields come straight from registers, so they stay stable while stalled.
  always_comb begin
    a_address_o = beat_addr;
    a_size_o    = tl_size;
    a_data_o    = wdata_q[lane*TlDw +: TlDw];
    a_source_o  = SourceId;
    if (!write_q) begin
      a_opcode_o = TL_GET;
    end else if (tl_size == 2'(TlOffW)) begin
      a_opcode_o = TL_PUT_FULL_DATA;
    end else begin
      a_opcode_o = TL_PUT_PARTIAL_DATA;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hreadyout_o = 1'b0;
    hresp_o     = HRESP_OKAY;
    a_valid_o   = 1'b0;
    d_ready_o   = 1'b0;
    case (state_q)
      IDLE: begin
        hreadyout_o = 1'b1;
        if (accept) begin
          if (bad_xfer) begin
            state_d = ERR1;
          end else if (hwrite_i) begin
            state_d = WDATA;
          end else begin
            state_d = REQ;
          end
        end
      end
      WDATA: state_d = REQ;
      REQ: begin
        a_valid_o = 1'b1;
        if (a_ready_i) begin
          state_d = RSP;
        end
      end
      RSP: begin
        d_ready_o = 1'b1;
        if (d_valid_i) begin
          if (d_error_i) begin
            state_d = ERR1;
          end else if (beat_q == last_beat_q) begin
            state_d = IDLE;
          end else begin
            state_d = REQ;
          end
        end
      end
      ERR1: begin
        hresp_o = HRESP_ERROR;
        state_d = ERR2;
      end
      ERR2: begin
        hresp_o     = HRESP_ERROR;
        hreadyout_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer context and read data; write responses never touch the read buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      wdata_q     <= '0;
      hrdata_q    <= '0;
      beat_q      <= '0;
      last_beat_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q      <= haddr_i;
            write_q     <= hwrite_i;
            size_q      <= hsize_i;
            beat_q      <= '0;
            last_beat_q <= last_beat_d;
          end
        end
        WDATA: wdata_q <= hwdata_i;
        RSP: begin
          if (d_valid_i && !d_error_i) begin
            if (!write_q) begin
              hrdata_q[lane*TlDw +: TlDw] <= d_data_i;
            end
            beat_q <= beat_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hrdata_o = hrdata_q;

endmodule

// File: doc/ahb_tl_downsize_bridge.md
AHB_TL_DOWNSIZE_BRIDGE -- requirements
Module: ahb_tl_downsize_bridge

Interface
REQ-001 SHALL have parameter AhbDw, default 64, AHB data width in bits.
REQ-002 SHALL have parameter TlDw, default 32, TL-UL data width in bits; legal when AhbDw = N*TlDw, N a power of two >= 1.
REQ-003 SHALL have parameter AddrW, default 32, address width for both buses.
REQ-004 SHALL have parameter SourceId, default 0, width TL_SRCW, driven on every a_source.
REQ-005 SHALL have ports clk_i in 1, the single clock, and rst_i in 1, the reset; reset is asynchronous and active-high.
REQ-006 SHALL have ports hsel_i in 1; haddr_i in AddrW; htrans_i in 2; hwrite_i in 1; hsize_i in 3; hwdata_i in AhbDw; hready_i in 1.
REQ-007 SHALL have ports hreadyout_o out 1; hresp_o out 1 (1=ERROR); hrdata_o out AhbDw.
REQ-008 SHALL have ports a_valid_o out 1; a_ready_i in 1; a_opcode_o out 3; a_size_o out 2; a_address_o out AddrW; a_mask_o out TlDw/8; a_data_o out TlDw; a_source_o out TL_SRCW.
REQ-009 SHALL have ports d_valid_i in 1; d_ready_o out 1; d_opcode_i in 3; d_error_i in 1; d_data_i in TlDw.

Function
REQ-010 An AHB transfer SHALL be accepted when hsel_i & hready_i & htrans_i in {NONSEQ, SEQ}; haddr, hwrite, hsize are registered.
REQ-011 IDLE/BUSY, or hsel_i low, SHALL get a zero-wait OKAY (hreadyout_o=1, hresp_o=0).
REQ-012 SHALL have FSM states IDLE, WDATA, REQ, RSP, ERR1, ERR2.
REQ-013 IDLE->WDATA on an accepted write; IDLE->REQ on an accepted read; IDLE->ERR1 on an accepted transfer with 2**hsize > AhbDw/8 or haddr not aligned to 2**hsize.
REQ-014 WDATA SHALL last one cycle, capture hwdata_i, then go to REQ; hreadyout_o=0 in every state except IDLE and ERR2.
REQ-015 Beat count = max(1, 2**hsize/(TlDw/8)); beat k SHALL use a_address = haddr + k*TlDw/8 and a_size = min(hsize, log2(TlDw/8)).
REQ-016 a_opcode SHALL be Get (4) for reads; for writes, PutFullData (0) when 2**a_size = TlDw/8, otherwise PutPartialData (1).
REQ-017 a_mask SHALL set the 2**a_size byte lanes selected by a_address modulo TlDw/8; a_data SHALL be the matching TlDw slice of the captured hwdata.
REQ-018 In REQ a_valid_o=1 with all A fields held stable until a_ready_i; on the handshake go to RSP; exactly one TL transaction outstanding.
REQ-019 In RSP d_ready_o=1, otherwise 0; on d_valid_i: if d_error_i go to ERR1; else store d_data_i into the hrdata lane selected by a_address, then REQ for the next beat, or IDLE after the last beat.
REQ-020 Remaining beats SHALL be abandoned after an error; no further A requests for that transfer.
REQ-021 ERR1: hresp_o=1, hreadyout_o=0; ERR2: hresp_o=1, hreadyout_o=1, then IDLE (AHB two-cycle error).
REQ-022 On return to IDLE, hreadyout_o=1 with hrdata_o valid for reads in that cycle; a new transfer may be accepted in that same cycle.
REQ-023 d_valid_i outside RSP SHALL be ignored; hrdata_o holds its last value between reads.

Reset
REQ-024 While rst_i=1, regardless of clock: state=IDLE, hreadyout_o=1, hresp_o=0, hrdata_o=0, a_valid_o=0, d_ready_o=0, beat counter 0.
REQ-025 Reset mid-transfer SHALL abandon the transfer without completing it on either bus.

Structure
REQ-026 htrans, A/D opcode encodings and the AHB response encodings SHALL live in the shared AHB and TL-UL packages; FSM state enum local.
REQ-027 Mask/lane generation SHALL be a sub-module tl_lane_mask (address, size -> mask, lane index).
REQ-028 The instance SHALL be rejected at elaboration ($fatal) if AhbDw mod TlDw != 0 or AhbDw < TlDw.

Verification
REQ-029 AhbDw=64/TlDw=32: write hsize=3, haddr 0x100, hwdata 0x1122334455667788 -> PutFullData 0x100 data 0x55667788, then 0x104 data 0x11223344, mask 0xF; AHB OKAY.
REQ-030 Read hsize=3 at 0x200, D data 0xAAAA0000 then 0x0000BBBB -> hrdata_o=0x0000BBBBAAAA0000 with hreadyout_o=1.
REQ-031 Write hsize=0 at 0x103, hwdata byte 0x5A -> one PutPartialData, a_size=0, mask 0x8, lane3=0x5A.
REQ-032 Read hsize=3, first D beat d_error_i=1 -> no second A request; ERR1 then ERR2 cycles.
REQ-033 hsize=2 at 0x102 (misaligned) -> no A traffic; two-cycle ERROR.
REQ-034 rst_i asserted while in RSP -> outputs immediately at reset values; next transfer completes normally.
